// File: rtl/sound_scheduler_pkg.sv
// Shared types and defaults for the sound-effect scheduler.
// Tables are packed with sound 0 in the most significant byte.
package sound_scheduler_pkg;

  localparam int unsigned NUM_SOUNDS_DEF = 4;
  localparam int unsigned CNT_W          = 8;
  localparam logic [NUM_SOUNDS_DEF*CNT_W-1:0] DUR_FRAMES_DEF = {8'd6, 8'd10, 8'd16, 8'd24};
  localparam int unsigned GAP_FRAMES_DEF = 1;

  typedef logic [$clog2(NUM_SOUNDS_DEF)-1:0] sound_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_t;

  // A zero-length table entry still plays for one frame.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/sound_scheduler_priority_encoder.sv
// Lowest-set-index encoder; index 0 has the highest priority.
module priority_encoder #(
  parameter  int unsigned NUM_SOUNDS = 4,
  localparam int unsigned IDW        = (NUM_SOUNDS > 1) ? $clog2(NUM_SOUNDS) : 1
) (
  input  logic [NUM_SOUNDS-1:0] req,
  output logic [IDW-1:0]        idx,
  output logic                  any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NUM_SOUNDS; i++) begin
      if (req[i] && !any) begin
        idx = IDW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// Priority scheduler gating sound effects to the tone generator, timed in video frames.
// Handles queueing, preemption by higher priority, retrigger, inter-sound gap and pause.
module sound_scheduler
  import sound_scheduler_pkg::*;
#(
  parameter  int unsigned                     NUM_SOUNDS = NUM_SOUNDS_DEF,
  parameter  logic [NUM_SOUNDS*CNT_W-1:0]     DUR_FRAMES = DUR_FRAMES_DEF,
  parameter  int unsigned                     GAP_FRAMES = GAP_FRAMES_DEF,
  localparam int unsigned                     IDW        = (NUM_SOUNDS > 1) ? $clog2(NUM_SOUNDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  startOfFrame,
  input  logic [NUM_SOUNDS-1:0] sound_requests,
  output logic                  tone_on,
  output logic [IDW-1:0]        tone_id,
  output logic                  play_start,
  output logic [NUM_SOUNDS-1:0] pending,
  output logic                  busy
);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [NUM_SOUNDS-1:0] pending_n;
  logic [IDW-1:0]        tone_id_n;
  logic                  start_n;
  logic [IDW-1:0]        pend_idx;
  logic                  pend_any;

  function automatic logic [CNT_W-1:0] dur_of(input logic [IDW-1:0] i);
    return at_least_one(DUR_FRAMES[(NUM_SOUNDS-1-int'(i))*CNT_W +: CNT_W]);
  endfunction

  priority_encoder #(.NUM_SOUNDS(NUM_SOUNDS)) u_prio (
    .req (pending),
    .idx (pend_idx),
    .any (pend_any)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pending_n = pending;
    tone_id_n = tone_id;
    start_n   = 1'b0;
    if (enable) begin
      pending_n = pending | sound_requests;
      unique case (state)
        ST_IDLE: begin
          if (pend_any) begin
            state_n             = ST_PLAY;
            tone_id_n           = pend_idx;
            cnt_n               = dur_of(pend_idx);
            pending_n[pend_idx] = 1'b0;
            start_n             = 1'b1;
          end
        end
        ST_PLAY: begin
          // A request for the sound now playing is a retrigger and is never queued.
          pending_n[tone_id] = 1'b0;
          if (pend_any && (pend_idx < tone_id)) begin
            tone_id_n           = pend_idx;
            cnt_n               = dur_of(pend_idx);
            pending_n[pend_idx] = 1'b0;
            start_n             = 1'b1;
          end else if (sound_requests[tone_id]) begin
            cnt_n   = dur_of(tone_id);
            start_n = 1'b1;
          end else if (startOfFrame) begin
            if (cnt <= 8'd1) begin
              if (GAP_FRAMES > 0) begin
                state_n = ST_GAP;
                cnt_n   = CNT_W'(GAP_FRAMES);
              end else begin
                state_n = ST_IDLE;
                cnt_n   = '0;
              end
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (startOfFrame) begin
            if (cnt <= 8'd1) begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= '0;
      tone_on    <= 1'b0;
      tone_id    <= '0;
      play_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pending    <= pending_n;
      tone_id    <= tone_id_n;
      play_start <= start_n;
      tone_on    <= enable && (state_n == ST_PLAY);
      busy       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench: a frame-level reference model predicts every cycle's outputs for
// a default instance and a zero-duration / zero-gap instance.
module tb_sound_scheduler;
  import sound_scheduler_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, enable, sof;
  logic [N-1:0] req;

  logic         tone_on_a, play_start_a, busy_a;
  sound_idx_t   tone_id_a;
  logic [N-1:0] pending_a;
  logic         tone_on_b, play_start_b, busy_b;
  sound_idx_t   tone_id_b;
  logic [N-1:0] pending_b;

  always #5 clk = ~clk;

  sound_scheduler dut_a (
    .clk(clk), .rst(rst), .enable(enable), .startOfFrame(sof), .sound_requests(req),
    .tone_on(tone_on_a), .tone_id(tone_id_a), .play_start(play_start_a),
    .pending(pending_a), .busy(busy_a)
  );

  sound_scheduler #(
    .NUM_SOUNDS(4),
    .DUR_FRAMES({8'd0, 8'd2, 8'd1, 8'd3}),
    .GAP_FRAMES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .startOfFrame(sof), .sound_requests(req),
    .tone_on(tone_on_b), .tone_id(tone_id_b), .play_start(play_start_b),
    .pending(pending_b), .busy(busy_b)
  );

  typedef struct {
    bit         playing;
    int         cur;
    int         remaining;
    int         gap_left;
    bit [N-1:0] pend;
  } model_t;

  typedef struct {
    bit         tone_on;
    int         tone_id;
    bit         chk_id;
    bit         play_start;
    bit [N-1:0] pending;
    bit         busy;
  } exp_t;

  model_t ma, mb;
  exp_t   qa[$], qb[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     dur_a[N] = '{6, 10, 16, 24};
  int     dur_b[N] = '{0, 2, 1, 3};

  // Frame-level behaviour: remaining frames of the current sound, gap frames left, request set.
  function automatic void step(inout model_t m, output exp_t e, input int dur[N], input int gap,
                               input bit r, input bit en, input bit f, input bit [N-1:0] rq);
    int         lo = -1;
    bit         started = 1'b0;
    bit [N-1:0] np;
    for (int i = N - 1; i >= 0; i--) if (m.pend[i]) lo = i;
    if (r) begin
      m.playing = 1'b0; m.cur = 0; m.remaining = 0; m.gap_left = 0; m.pend = '0;
    end else if (en) begin
      np = m.pend | rq;
      if (m.playing) np[m.cur] = 1'b0;
      if (lo >= 0 && ((!m.playing && m.gap_left == 0) || (m.playing && lo < m.cur))) begin
        m.playing   = 1'b1;
        m.cur       = lo;
        m.remaining = (dur[lo] == 0) ? 1 : dur[lo];
        np[lo]      = 1'b0;
        started     = 1'b1;
      end else if (m.playing && rq[m.cur]) begin
        m.remaining = (dur[m.cur] == 0) ? 1 : dur[m.cur];
        started     = 1'b1;
      end else if (m.playing && f) begin
        m.remaining--;
        if (m.remaining == 0) begin
          m.playing  = 1'b0;
          m.gap_left = gap;
        end
      end else if (m.gap_left > 0 && f) begin
        m.gap_left--;
      end
      m.pend = np;
    end
    e.tone_on    = en && !r && m.playing;
    e.tone_id    = m.cur;
    e.chk_id     = e.tone_on || r;
    e.play_start = started;
    e.pending    = m.pend;
    e.busy       = m.playing || (m.gap_left > 0);
  endfunction

  task automatic drive(input bit r, input bit en, input bit f, input bit [N-1:0] rq);
    exp_t ea, eb;
    @(negedge clk);
    rst = r; enable = en; sof = f; req = rq;
    step(ma, ea, dur_a, 1, r, en, f, rq);
    qa.push_back(ea);
    step(mb, eb, dur_b, 0, r, en, f, rq);
    qb.push_back(eb);
    cyc++;
  endtask

  // Frames every 4 cycles; the request pattern is pulsed on the first cycle only.
  task automatic frames(input int n, input bit en, input bit [N-1:0] rq0);
    for (int i = 0; i < n; i++) drive(1'b0, en, (cyc % 4) == 3, (i == 0) ? rq0 : '0);
  endtask

  task automatic check(input string nm, input exp_t e, input logic ton, input sound_idx_t tid,
                       input logic ps, input logic [N-1:0] pd, input logic bz);
    vectors++;
    if (ton !== e.tone_on || ps !== e.play_start || pd !== e.pending || bz !== e.busy ||
        (e.chk_id && tid !== sound_idx_t'(e.tone_id))) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got on=%b id=%0d start=%b pend=%b busy=%b, want on=%b id=%0d start=%b pend=%b busy=%b",
               nm, cyc, ton, tid, ps, pd, bz, e.tone_on, e.tone_id, e.play_start, e.pending, e.busy);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("inst_a", e, tone_on_a, tone_id_a, play_start_a, pending_a, busy_a);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("inst_b", e, tone_on_b, tone_id_b, play_start_b, pending_b, busy_b);
      end
    end
  end

  initial begin
    bit         r, en, f;
    bit [N-1:0] rq;
    exp_t       dummy;
    rst = 1'b1; enable = 1'b0; sof = 1'b0; req = '0;
    step(ma, dummy, dur_a, 1, 1'b1, 1'b0, 1'b0, '0);
    step(mb, dummy, dur_b, 0, 1'b1, 1'b0, 1'b0, '0);

    repeat (3) drive(1'b1, 1'b1, 1'b0, '0);
    frames(5, 1'b1, '0);
    frames(90, 1'b1, 4'b0100);                          // single request, sound 2
    frames(20, 1'b1, 4'b1000);                          // sound 3 ...
    frames(40, 1'b1, 4'b0001);                          // ... preempted by sound 0
    frames(8, 1'b1, 4'b0001);
    frames(180, 1'b1, 4'b1010);                         // queueing behind sound 0
    frames(30, 1'b1, 4'b0010);
    frames(60, 1'b1, 4'b0010);                          // retrigger of sound 1
    frames(12, 1'b1, 4'b0100);
    frames(20, 1'b0, 4'b0001);                          // pause, request ignored
    frames(80, 1'b1, '0);
    frames(8, 1'b1, 4'b0001);
    frames(4, 1'b1, 4'b0110);
    drive(1'b1, 1'b1, 1'b0, 4'b1000);                   // reset mid-play with pending
    frames(10, 1'b1, '0);
    drive(1'b0, 1'b1, 1'b1, 4'b0001);                   // grant and expiry-edge corner on inst_b
    frames(10, 1'b1, 4'b0001);

    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 9) != 0);
      f  = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < N; b++) rq[b] = ($urandom_range(0, 14) == 0);
      drive(r, en, f, rq);
    end
    frames(150, 1'b1, '0);

    repeat (3) @(posedge clk);
    #2;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, want 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
